// File: rtl/ex_pkg.sv
// ============================================================================
// Module   : ex_pkg
// Brief    : Shared widths, ALU op codes and divider state encodings for EX.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ex_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 8;

    localparam logic [REG_W-1:0]      ZERO_WORD    = 32'h0000_0000;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = 5'b00000;

    localparam logic [ALU_OP_W-1:0] EXE_NOP_OP  = 8'h00;
    localparam logic [ALU_OP_W-1:0] EXE_SRL_OP  = 8'h02;
    localparam logic [ALU_OP_W-1:0] EXE_SRA_OP  = 8'h03;
    localparam logic [ALU_OP_W-1:0] EXE_DIV_OP  = 8'h1A;
    localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP = 8'h1B;
    localparam logic [ALU_OP_W-1:0] EXE_ADDU_OP = 8'h21;
    localparam logic [ALU_OP_W-1:0] EXE_SUBU_OP = 8'h23;
    localparam logic [ALU_OP_W-1:0] EXE_AND_OP  = 8'h24;
    localparam logic [ALU_OP_W-1:0] EXE_OR_OP   = 8'h25;
    localparam logic [ALU_OP_W-1:0] EXE_XOR_OP  = 8'h26;
    localparam logic [ALU_OP_W-1:0] EXE_NOR_OP  = 8'h27;
    localparam logic [ALU_OP_W-1:0] EXE_SLT_OP  = 8'h2A;
    localparam logic [ALU_OP_W-1:0] EXE_SLTU_OP = 8'h2B;
    localparam logic [ALU_OP_W-1:0] EXE_SLL_OP  = 8'h7C;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Two's-complement negate when en is set; also yields the magnitude of
    // 0x80000000 correctly when read as unsigned.
    function automatic logic [REG_W-1:0] neg_if(input logic [REG_W-1:0] v,
                                                input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_div.sv
// ============================================================================
// Module   : ex_div
// Brief    : Iterative 32-step restoring divider with signed fixup (IDLE/BUSY/DONE).
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_div
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [REG_W-1:0]  opdata1_i,
    input  logic [REG_W-1:0]  opdata2_i,
    output logic              ready_o,
    output logic [63:0]       result_o
);

    div_state_t        r_state;
    logic [4:0]        r_cnt;
    logic [REG_W-1:0]  r_rem;
    logic [REG_W-1:0]  r_quot;
    logic [REG_W-1:0]  r_divisor;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [63:0]       r_result;

    logic [REG_W:0]    w_shift;
    logic [REG_W:0]    w_sub;
    logic              w_ge;
    logic [REG_W-1:0]  w_rem_next;
    logic [REG_W-1:0]  w_quot_next;
    logic              w_neg1;
    logic              w_neg2;

    // Dividend bits shift out of the quotient register into the partial
    // remainder one per step; the freed LSB collects the quotient bit.
    always_comb begin
        w_shift     = {r_rem, r_quot[REG_W-1]};
        w_sub       = w_shift - {1'b0, r_divisor};
        w_ge        = (w_shift >= {1'b0, r_divisor});
        w_rem_next  = w_ge ? w_sub[REG_W-1:0] : w_shift[REG_W-1:0];
        w_quot_next = {r_quot[REG_W-2:0], w_ge};
        w_neg1      = signed_i & opdata1_i[REG_W-1];
        w_neg2      = signed_i & opdata2_i[REG_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= 5'd0;
            r_rem     <= ZERO_WORD;
            r_quot    <= ZERO_WORD;
            r_divisor <= ZERO_WORD;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= 64'd0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (start_i) begin
                        if (opdata2_i == ZERO_WORD) begin
                            r_result <= 64'd0;
                            r_state  <= DIV_DONE;
                        end else begin
                            r_rem     <= ZERO_WORD;
                            r_quot    <= neg_if(opdata1_i, w_neg1);
                            r_divisor <= neg_if(opdata2_i, w_neg2);
                            r_neg_q   <= w_neg1 ^ w_neg2;
                            r_neg_r   <= w_neg1;
                            r_cnt     <= 5'd0;
                            r_state   <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    r_rem  <= w_rem_next;
                    r_quot <= w_quot_next;
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_result <= {neg_if(w_rem_next, r_neg_r),
                                     neg_if(w_quot_next, r_neg_q)};
                        r_state  <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    r_state <= DIV_IDLE;
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign ready_o  = (r_state == DIV_DONE);
    assign result_o = r_result;

endmodule

`default_nettype wire

// File: rtl/ex.sv
// ============================================================================
// Module   : ex
// Brief    : MIPS32 execute stage: ALU, divider stall control and EX/MEM latch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex
    import ex_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALU_OP_W-1:0]   aluop_i,
    input  logic [REG_W-1:0]      reg1_i,
    input  logic [REG_W-1:0]      reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  whilo_o,
    output logic [REG_W-1:0]      hi_o,
    output logic [REG_W-1:0]      lo_o,
    output logic                  stallreq_o
);

    logic              w_is_div;
    logic              w_div_ready;
    logic [63:0]       w_div_result;
    logic [REG_W-1:0]  w_alu;
    logic [4:0]        w_sa;

    assign w_is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign w_sa     = reg1_i[4:0];

    ex_div u_div (
        .clk       (clk),
        .rst       (rst),
        .start_i   (w_is_div),
        .signed_i  (aluop_i == EXE_DIV_OP),
        .opdata1_i (reg1_i),
        .opdata2_i (reg2_i),
        .ready_o   (w_div_ready),
        .result_o  (w_div_result)
    );

    // Inputs are held during a stall, so a divide op is still on aluop_i
    // in every IDLE-with-start and BUSY cycle; DONE releases the pipeline.
    assign stallreq_o = w_is_div && !w_div_ready;

    always_comb begin
        w_alu = ZERO_WORD;
        case (aluop_i)
            EXE_ADDU_OP: w_alu = reg1_i + reg2_i;
            EXE_SUBU_OP: w_alu = reg1_i - reg2_i;
            EXE_AND_OP:  w_alu = reg1_i & reg2_i;
            EXE_OR_OP:   w_alu = reg1_i | reg2_i;
            EXE_XOR_OP:  w_alu = reg1_i ^ reg2_i;
            EXE_NOR_OP:  w_alu = ~(reg1_i | reg2_i);
            EXE_SLT_OP:  w_alu = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
            EXE_SLTU_OP: w_alu = {31'd0, reg1_i < reg2_i};
            EXE_SLL_OP:  w_alu = reg2_i << w_sa;
            EXE_SRL_OP:  w_alu = reg2_i >> w_sa;
            EXE_SRA_OP:  w_alu = $unsigned($signed(reg2_i) >>> w_sa);
            default:     w_alu = ZERO_WORD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_o    <= NOP_REG_ADDR;
            wreg_o  <= 1'b0;
            wdata_o <= ZERO_WORD;
            whilo_o <= 1'b0;
            hi_o    <= ZERO_WORD;
            lo_o    <= ZERO_WORD;
        end else if (stallreq_o) begin
            wd_o    <= NOP_REG_ADDR;
            wreg_o  <= 1'b0;
            wdata_o <= ZERO_WORD;
            whilo_o <= 1'b0;
        end else if (w_div_ready) begin
            wd_o    <= wd_i;
            wreg_o  <= 1'b0;
            wdata_o <= ZERO_WORD;
            whilo_o <= 1'b1;
            hi_o    <= w_div_result[63:32];
            lo_o    <= w_div_result[31:0];
        end else begin
            wd_o    <= wd_i;
            wreg_o  <= wreg_i;
            wdata_o <= w_alu;
            whilo_o <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex.sv
// ============================================================================
// Module   : tb_ex
// Brief    : Scoreboard bench for the EX stage: directed ALU and divide vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ex;

    logic        clk;
    logic        rst;
    logic [7:0]  aluop;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    ex dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop),
        .reg1_i     (reg1),
        .reg2_i     (reg2),
        .wd_i       (wd),
        .wreg_i     (wreg),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: every write toward MEM (GPR or HI/LO) must match the oldest
    // outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (wreg_o || whilo_o)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: wreg_o=%0b whilo_o=%0b wd_o=%0d wdata_o=%h",
                         wreg_o, whilo_o, wd_o, wdata_o);
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check32({nm, ".wreg"},  {31'd0, wreg_o},  {31'd0, e.wreg});
                check32({nm, ".whilo"}, {31'd0, whilo_o}, {31'd0, e.whilo});
                check32({nm, ".wd"},    {27'd0, wd_o},    {27'd0, e.wd});
                if (e.wreg)
                    check32({nm, ".wdata"}, wdata_o, e.wdata);
                if (e.whilo) begin
                    check32({nm, ".hi"}, hi_o, e.hi);
                    check32({nm, ".lo"}, lo_o, e.lo);
                end
            end
        end
    end

    task automatic idle_inputs();
        aluop = 8'h00;
        reg1  = 32'd0;
        reg2  = 32'd0;
        wd    = 5'd0;
        wreg  = 1'b0;
    endtask

    // Presents one instruction, holds it while stalled, and checks the
    // stall length. Returns with the NOP applied just after the result edge.
    task automatic issue(input string nm, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic we,
                         input int exp_stall, input exp_t e);
        int n;
        aluop = op;
        reg1  = a;
        reg2  = b;
        wd    = d;
        wreg  = we;
        if (e.wreg || e.whilo) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        n = 0;
        @(negedge clk);
        while (stallreq_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        check32({nm, ".stall_cycles"}, n, exp_stall);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    function automatic exp_t alu_e(input logic [4:0] d, input logic [31:0] v);
        exp_t e;
        e.wd = d; e.wreg = 1'b1; e.wdata = v; e.whilo = 1'b0; e.hi = 32'd0; e.lo = 32'd0;
        return e;
    endfunction

    function automatic exp_t div_e(input logic [4:0] d, input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.wd = d; e.wreg = 1'b0; e.wdata = 32'd0; e.whilo = 1'b1; e.hi = h; e.lo = l;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check32("reset.wd",       {27'd0, wd_o},      32'd0);
        check32("reset.wreg",     {31'd0, wreg_o},    32'd0);
        check32("reset.wdata",    wdata_o,            32'd0);
        check32("reset.whilo",    {31'd0, whilo_o},   32'd0);
        check32("reset.hi",       hi_o,               32'd0);
        check32("reset.lo",       lo_o,               32'd0);
        check32("reset.stallreq", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk);
        #1;

        issue("addu",  8'h21, 32'h7FFF_FFFF, 32'h0000_0001, 5'd5,  1'b1, 0, alu_e(5'd5,  32'h8000_0000));
        issue("sra",   8'h03, 32'h0000_0004, 32'hF000_0000, 5'd6,  1'b1, 0, alu_e(5'd6,  32'hFF00_0000));
        issue("srl",   8'h02, 32'h0000_0004, 32'hF000_0000, 5'd7,  1'b1, 0, alu_e(5'd7,  32'h0F00_0000));
        issue("sll",   8'h7C, 32'h0000_0004, 32'h8000_0001, 5'd8,  1'b1, 0, alu_e(5'd8,  32'h0000_0010));
        issue("slt",   8'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 5'd9,  1'b1, 0, alu_e(5'd9,  32'h0000_0001));
        issue("sltu",  8'h2B, 32'hFFFF_FFFF, 32'h0000_0001, 5'd10, 1'b1, 0, alu_e(5'd10, 32'h0000_0000));
        issue("subu",  8'h23, 32'h0000_0000, 32'h0000_0001, 5'd11, 1'b1, 0, alu_e(5'd11, 32'hFFFF_FFFF));
        issue("and",   8'h24, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd12, 1'b1, 0, alu_e(5'd12, 32'h0F00_0F00));
        issue("xor",   8'h26, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd13, 1'b1, 0, alu_e(5'd13, 32'hF00F_F00F));
        issue("nor",   8'h27, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd14, 1'b1, 0, alu_e(5'd14, 32'h00F0_00F0));
        issue("unkop", 8'h55, 32'h1234_5678, 32'h1111_1111, 5'd15, 1'b1, 0, alu_e(5'd15, 32'h0000_0000));

        issue("div_m7_2",  8'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 5'd3, 1'b1, 33,
              div_e(5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD));
        issue("div_7_m2",  8'h1A, 32'h0000_0007, 32'hFFFF_FFFE, 5'd3, 1'b1, 33,
              div_e(5'd3, 32'h0000_0001, 32'hFFFF_FFFD));
        issue("divu_big",  8'h1B, 32'hFFFF_FFFF, 32'h0000_000A, 5'd3, 1'b0, 33,
              div_e(5'd3, 32'h0000_0005, 32'h1999_9999));
        issue("divu_by0",  8'h1B, 32'h0000_0064, 32'h0000_0000, 5'd4, 1'b0, 1,
              div_e(5'd4, 32'h0000_0000, 32'h0000_0000));

        // Reset while BUSY with cnt = 10 (presented at T, cnt 10 in T+11).
        aluop = 8'h1B; reg1 = 32'd100; reg2 = 32'd3; wd = 5'd2; wreg = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check32("rstmid.wd",       {27'd0, wd_o},       32'd0);
        check32("rstmid.wreg",     {31'd0, wreg_o},     32'd0);
        check32("rstmid.wdata",    wdata_o,             32'd0);
        check32("rstmid.whilo",    {31'd0, whilo_o},    32'd0);
        check32("rstmid.hi",       hi_o,                32'd0);
        check32("rstmid.lo",       lo_o,                32'd0);
        check32("rstmid.stallreq", {31'd0, stallreq_o}, 32'd0);

        issue("divu_9_4", 8'h1B, 32'd9, 32'd4, 5'd1, 1'b0, 33,
              div_e(5'd1, 32'd1, 32'd2));
        issue("divu_9_4b", 8'h1B, 32'd9, 32'd4, 5'd1, 1'b0, 33,
              div_e(5'd1, 32'd1, 32'd2));
        issue("or_after_div", 8'h25, 32'h0000_00F0, 32'h0000_000F, 5'd20, 1'b1, 0,
              alu_e(5'd20, 32'h0000_00FF));

        repeat (4) @(posedge clk);
        #1;
        check32("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex.md
# ex

Execute stage of the five-stage MIPS32 pipeline, between the ID/EX latch and the MEM stage. It evaluates one ALU operation per cycle and registers the result toward MEM: the EX/MEM latch lives inside this block. It also runs DIV/DIVU on an iterative 32-cycle divider, holding the pipeline through `stallreq_o` until the HI/LO result is ready.

## Interface
Parameters: none; all widths and op codes come from `define.v`.
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high (`RstEnable` = 1'b1).
- `aluop_i` in 8 (`AluOpBus`): operation code.
- `reg1_i` in 32 (`RegBus`): operand 1. For shifts, `reg1_i[4:0]` is the shift amount.
- `reg2_i` in 32: operand 2. For shifts, the value to shift. For division, the divisor.
- `wd_i` in 5 (`RegAddrBus`): destination GPR.
- `wreg_i` in 1: GPR write enable.
- `wd_o` out 5: registered destination to MEM.
- `wreg_o` out 1: registered GPR write enable.
- `wdata_o` out 32: registered ALU result.
- `whilo_o` out 1: registered HI/LO write enable.
- `hi_o` out 32, `lo_o` out 32: registered HI/LO values.
- `stallreq_o` out 1: combinational stall request to the pipeline controller.

## Operation
- Op codes (hex): NOP 00, SRL 02, SRA 03, DIV 1A, DIVU 1B, ADDU 21, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLTU 2B, SLL 7C.
- Logic and arithmetic ops:
  - ADDU and SUBU wrap mod 2^32 and raise no overflow.
  - SLT is a signed compare, SLTU unsigned; the result is 32'd1 or 32'd0.
  - SRA sign-fills.
- Unknown op: `wdata_o` = `ZeroWord`; `wreg_o` still follows `wreg_i`.
- DIV/DIVU: `wreg_o` = 0, `whilo_o` = 1, `lo_o` = quotient, `hi_o` = remainder.
  - Signed DIV divides magnitudes.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Divisor 0 gives `hi_o` = `lo_o` = 0.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE: on DIV/DIVU with `reg2_i` ≠ 0, load magnitudes, set cnt = 0 and go to BUSY. With `reg2_i` = 0, go to DONE with a zero result.
  - BUSY: one restoring-division step per cycle. At cnt = 31, go to DONE.
  - DONE: result valid; always return to IDLE.
- `stallreq_o` = 1 in IDLE when a DIV/DIVU is presented, and throughout BUSY. It is 0 in DONE and for all other ops.
- The controller holds all `_i` inputs stable while `stallreq_o` = 1.
- Output register, in priority order:
  - While `stallreq_o` = 1 it loads a bubble: `wd_o` = `NOPRegAddr`, `wreg_o` = 0, `whilo_o` = 0, `wdata_o` = 0.
  - In DONE it loads the division result.
  - Otherwise it loads the ALU result and passes `wd_i`/`wreg_i` through.

## Timing
- Reset clears every output to 0 (`wd_o` = `NOPRegAddr`), sets FSM = IDLE and cnt = 0. Reset mid-division abandons the operation.
- ALU ops have 1-cycle latency: inputs at cycle T appear on the outputs after the posedge ending T.
- DIV, divisor ≠ 0, presented at T:
  - `stallreq_o` is high for T..T+32 (33 cycles).
  - DONE is at T+33; HI/LO appear after the posedge ending T+33.
- DIV, divisor = 0, presented at T: stall for cycle T only, DONE at T+1.
- Back-to-back DIVs: the second starts from IDLE in the cycle after DONE. There is no dead cycle beyond DONE.
- `hi_o`/`lo_o` hold their value when `whilo_o` = 0. Consumers qualify on `whilo_o`.

## Structure
- `define.v` gains `AluOpBus` and every op code above.
- `define.v` also gains the divider state encodings `DivIdle`, `DivBusy`, `DivDone`.
- Sub-module `div` (`div.v`) owns the FSM, the 32-step datapath and the sign fixup.
  - Ports: `clk`, `rst`, `start_i`, `signed_i`, `opdata1_i`, `opdata2_i`.
  - Outputs: `ready_o` (high in DONE) and `result_o[63:0]` = {remainder, quotient}.
- `ex` holds the ALU, the stall logic and the output register.

## Test plan
- ADDU 7FFFFFFF + 00000001 → next cycle `wdata_o` = 80000000, `wreg_o` = 1, `wd_o` = `wd_i`.
- SRA with `reg1_i` = 4, `reg2_i` = F0000000 → `wdata_o` = FF000000. SLT FFFFFFFF vs 1 → 1; SLTU on the same operands → 0.
- DIV -7 / 2 → `stallreq_o` high for 33 cycles; `whilo_o` = 1, `lo_o` = FFFFFFFD, `hi_o` = FFFFFFFF; `wreg_o` = 0 throughout.
- DIVU 100 / 0 → stall for 1 cycle; `hi_o` = `lo_o` = 0, `whilo_o` = 1.
- Assert `rst` at BUSY cnt = 10 → next cycle all outputs are 0 and `stallreq_o` = 0. A following DIVU 9 / 4 gives `lo_o` = 2, `hi_o` = 1.
- DIVU 9 / 4 immediately followed by OR → the OR result appears one cycle after the HI/LO write, with no lost or duplicated writes.
